c906_axi_sram_slv: RTL
======================

Name: c906_axi_sram_slv

Overview:
- AXI4 slave responder for the C906 128-bit BIU master port: on-chip SRAM at BASE_ADDR, reachable from the core's AXI bus after the interconnect.
- Independent read and write channel FSMs over a dual-port byte-enabled array.
- Supports FIXED/INCR/WRAP bursts up to 16 beats.
- Single outstanding transaction per direction.

Parameters:
- ADDR_W, 40, AXI address width.
- DATA_W, 128, AXI data width; byte lanes = DATA_W/8.
- ID_W, 8, AXI ID width.
- MEM_BYTES, 65536, SRAM size in bytes; power of two and a multiple of DATA_W/8.
- BASE_ADDR, 40'h0000000000, first byte address; aligned to MEM_BYTES.

Ports:
- pll_core_cpuclk  in  1  clock
- pad_cpu_rst_b  in  1  asynchronous active-low reset
- aw_id/aw_addr/aw_len/aw_size/aw_burst  in  ID_W/ADDR_W/8/3/2  write address
- aw_valid in 1; aw_ready out 1
- w_data/w_strb/w_last/w_valid  in  DATA_W/DATA_W/8/1/1; w_ready out 1
- b_id/b_resp/b_valid  out  ID_W/2/1; b_ready in 1
- ar_id/ar_addr/ar_len/ar_size/ar_burst  in  ID_W/ADDR_W/8/3/2  read address
- ar_valid in 1; ar_ready out 1
- r_id/r_data/r_resp/r_last/r_valid  out  ID_W/DATA_W/2/1/1; r_ready in 1
- aw/ar lock, cache and prot are not ported; the wrapper ties them off.

Behaviour:
- Reset:
  - Reset is pad_cpu_rst_b, asynchronous, active-low; clock is pll_core_cpuclk.
  - All valid/ready outputs reset to 0; id/resp/data/last reset to 0.
  - Both FSMs reset to IDLE. Array contents are not reset.
  - Reset asserted mid-burst aborts the burst immediately; no B/R beat completes.
- Word index: (addr - BASE_ADDR)[log2(MEM_BYTES)-1 : log2(DATA_W/8)].
- In range: BASE_ADDR <= addr < BASE_ADDR+MEM_BYTES, checked per beat.
- Next address (shared sub-module), incr = 1<<size:
  - FIXED (00): address unchanged.
  - INCR (01): addr + incr.
  - WRAP (10), len in {1,3,7,15}: bound = (len+1)*incr; next = (addr & ~(bound-1)) | ((addr+incr) & (bound-1)).
  - WRAP with any other len, and burst 11: treated as INCR.
- Illegal size: size > log2(DATA_W/8) makes the whole burst SLVERR (2'b10). Writes are suppressed and reads return 0.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: aw_ready=1. On aw handshake, latch id/addr/len/size/burst, clear beat count and error flag, go to W_DATA.
  - W_DATA: w_ready=1. Each w handshake writes the bytes with w_strb=1 at the word index, only if in range and size is legal; otherwise it sets the error flag.
    - Address advances and beat count increments.
    - Beat count is authoritative: the (len+1)th beat ends the burst.
    - w_last asserted on any other beat, or deasserted on the final beat, sets the error flag.
  - W_RESP: b_valid=1, b_id=latched id, b_resp = error ? 2'b10 : 2'b00. On b_ready go to W_IDLE.
  - aw_ready is not re-asserted until the cycle after the B handshake.
- Read FSM R_IDLE -> R_READ -> R_DATA:
  - R_IDLE: ar_ready=1. On handshake, latch fields and go to R_READ.
  - R_READ: synchronous array read of the first beat; go to R_DATA. r_valid asserts 2 cycles after the ar handshake edge.
  - R_DATA: r_valid=1, r_id=latched id, r_last = (beat==len). r_resp is per beat: 2'b10 if out of range or illegal size, else 2'b00. r_data=0 on error beats.
    - Data is held stable while r_ready=0.
    - On handshake with r_last=0, the next beat is read in the same cycle from the next address; r_valid stays 1, giving 1 beat/cycle sustained.
    - On handshake with r_last=1, go to R_IDLE.
- Simultaneous read and write to the same word in one cycle: the read returns the pre-write data. The channels never stall each other.
- len up to 255 is accepted for INCR (AXI4); beat counter is 8 bits.

Decomposition:
- Package c906_axi_pkg holds:
  - burst_t enum FIXED/INCR/WRAP;
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - the write-FSM and read-FSM state enums.
- Sub-module axi_burst_addr_gen is purely combinational: addr, size, len, burst -> next_addr. It is instantiated once for write and once for read.
- The array is inferred in the top module as a dual-port array with byte write enables.

Test Plan:
- INCR write, then read back:
  - Stimulus: aw_addr=0x100, len=3, size=4, burst=INCR, data 0x11..,0x22..,0x33..,0x44.., all strobes set; then ar with the same fields.
  - Response: bresp=OKAY; reads return the 4 words in order; r_last only on beat 3; first r_valid 2 cycles after ar handshake; 4 consecutive beats with r_ready=1.
- WRAP read:
  - Stimulus: preload words at 0x00..0x30; ar_addr=0x20, len=3, size=4, burst=WRAP.
  - Response: beats come from 0x20, 0x30, 0x00, 0x10.
- Partial strobe:
  - Stimulus: write 0xFF.. to 0x40, then a single beat with w_strb=16'h000F and data 0xAA..
  - Response: readback = low 4 bytes 0xAA, upper 12 bytes 0xFF.
- Out of range:
  - Stimulus: aw_addr=BASE_ADDR+MEM_BYTES, len=0.
  - Response: bresp=2'b10 and memory unchanged. ar at the same address returns r_resp=2'b10, r_data=0.
  - Stimulus: INCR len=1 starting at the last word.
  - Response: beat 0 OKAY, beat 1 SLVERR.
- Backpressure and concurrency:
  - Stimulus: r_ready toggling 1010; b_ready held 0 for 5 cycles; simultaneous write/read of word 0x80 (old 0x5A.., new 0xC3..).
  - Response: r_data stable while stalled; b_valid held with aw_ready=0; same-cycle read returns 0x5A..
- Reset mid-burst:
  - Stimulus: assert pad_cpu_rst_b=0 after beat 1 of a len=7 read, then release.
  - Response: all valid/ready outputs 0 during reset; both FSMs return to IDLE; the next transaction completes normally.

Source files
------------

// File: rtl/c906_axi_pkg.sv
// Shared types for the C906 AXI SRAM slave: burst encodings, response codes
// and the write/read channel state machines.
package c906_axi_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_DATA} rstate_t;

endpackage

// File: rtl/c906_axi_sram_slv_addr_gen.sv
// Combinational AXI burst next-address calculator (FIXED/INCR/WRAP).
module axi_burst_addr_gen
    import c906_axi_pkg::*;
#(
    parameter int ADDR_W = 40
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [2:0]        i_size,
    input  logic [7:0]        i_len,
    input  logic [1:0]        i_burst,
    output logic [ADDR_W-1:0] o_next_addr
);

    logic [ADDR_W-1:0] w_incr;
    logic [ADDR_W-1:0] w_mask;
    logic              w_wrap_ok;

    assign w_incr    = ADDR_W'(1) << i_size;
    assign w_mask    = ((ADDR_W'(i_len) + ADDR_W'(1)) << i_size) - ADDR_W'(1);
    assign w_wrap_ok = (i_len == 8'd1) || (i_len == 8'd3) || (i_len == 8'd7) || (i_len == 8'd15);

    // Reserved burst encoding and WRAP with an unsupported length fall back to INCR.
    always_comb begin
        o_next_addr = i_addr + w_incr;
        if (i_burst == FIXED)
            o_next_addr = i_addr;
        else if (i_burst == WRAP && w_wrap_ok)
            o_next_addr = (i_addr & ~w_mask) | ((i_addr + w_incr) & w_mask);
    end

endmodule

// File: rtl/c906_axi_sram_slv.sv
// AXI4 SRAM slave for the C906 BIU: independent write/read FSMs, one
// outstanding burst per direction, dual-port byte-enabled array.
module c906_axi_sram_slv
    import c906_axi_pkg::*;
#(
    parameter int              ADDR_W    = 40,
    parameter int              DATA_W    = 128,
    parameter int              ID_W      = 8,
    parameter int              MEM_BYTES = 65536,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                  pll_core_cpuclk,
    input  logic                  pad_cpu_rst_b,
    input  logic [ID_W-1:0]       aw_id,
    input  logic [ADDR_W-1:0]     aw_addr,
    input  logic [7:0]            aw_len,
    input  logic [2:0]            aw_size,
    input  logic [1:0]            aw_burst,
    input  logic                  aw_valid,
    output logic                  aw_ready,
    input  logic [DATA_W-1:0]     w_data,
    input  logic [DATA_W/8-1:0]   w_strb,
    input  logic                  w_last,
    input  logic                  w_valid,
    output logic                  w_ready,
    output logic [ID_W-1:0]       b_id,
    output logic [1:0]            b_resp,
    output logic                  b_valid,
    input  logic                  b_ready,
    input  logic [ID_W-1:0]       ar_id,
    input  logic [ADDR_W-1:0]     ar_addr,
    input  logic [7:0]            ar_len,
    input  logic [2:0]            ar_size,
    input  logic [1:0]            ar_burst,
    input  logic                  ar_valid,
    output logic                  ar_ready,
    output logic [ID_W-1:0]       r_id,
    output logic [DATA_W-1:0]     r_data,
    output logic [1:0]            r_resp,
    output logic                  r_last,
    output logic                  r_valid,
    input  logic                  r_ready
);

    localparam int NB     = DATA_W / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int IDX_W  = $clog2(MEM_BYTES);
    localparam int WIDX_W = IDX_W - OFF_W;
    localparam int WORDS  = MEM_BYTES / NB;

    // Below-base addresses wrap to a huge offset, so one compare covers both bounds.
    function automatic logic f_ok(input logic [ADDR_W-1:0] a, input logic [2:0] sz);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return (off < ADDR_W'(MEM_BYTES)) && (sz <= 3'(OFF_W));
    endfunction

    function automatic logic [WIDX_W-1:0] f_idx(input logic [ADDR_W-1:0] a);
        return WIDX_W'((a - BASE_ADDR) >> OFF_W);
    endfunction

    logic [DATA_W-1:0] r_mem [WORDS];
    logic [DATA_W-1:0] r_rmem_q;

    // Write channel
    wstate_t           r_wst;
    logic [ID_W-1:0]   r_wid;
    logic [ADDR_W-1:0] r_waddr;
    logic [7:0]        r_wlen, r_wbeat;
    logic [2:0]        r_wsize;
    logic [1:0]        r_wburst, r_bresp;
    logic              r_werr, r_aw_rdy, r_w_rdy, r_b_vld;
    logic [ADDR_W-1:0] w_wnext;
    logic              w_wfire, w_wlast_beat, w_werr_nxt;

    // Read channel
    rstate_t           r_rst;
    logic [ID_W-1:0]   r_rid;
    logic [ADDR_W-1:0] r_raddr;
    logic [7:0]        r_rlen, r_rbeat;
    logic [2:0]        r_rsize;
    logic [1:0]        r_rburst, r_rresp;
    logic              r_ar_rdy, r_rd_vld, r_rlast;
    logic [ADDR_W-1:0] w_rnext;
    logic              w_rd_en;

    axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_wgen (
        .i_addr(r_waddr), .i_size(r_wsize), .i_len(r_wlen), .i_burst(r_wburst), .o_next_addr(w_wnext)
    );
    axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_rgen (
        .i_addr(r_raddr), .i_size(r_rsize), .i_len(r_rlen), .i_burst(r_rburst), .o_next_addr(w_rnext)
    );

    assign aw_ready = r_aw_rdy;
    assign w_ready  = r_w_rdy;
    assign b_valid  = r_b_vld;
    assign b_id     = r_wid;
    assign b_resp   = r_bresp;
    assign ar_ready = r_ar_rdy;
    assign r_valid  = r_rd_vld;
    assign r_id     = r_rid;
    assign r_resp   = r_rresp;
    assign r_last   = r_rlast;
    assign r_data   = (r_rd_vld && (r_rresp == RESP_OKAY)) ? r_rmem_q : '0;

    assign w_wfire      = (r_wst == W_DATA) && w_valid && r_w_rdy;
    assign w_wlast_beat = (r_wbeat == r_wlen);
    assign w_werr_nxt   = r_werr | ~f_ok(r_waddr, r_wsize) | (w_last != w_wlast_beat);
    assign w_rd_en      = (r_rst == R_READ) || ((r_rst == R_DATA) && r_ready && !r_rlast);

    always_ff @(posedge pll_core_cpuclk) begin
        if (w_wfire && f_ok(r_waddr, r_wsize))
            for (int b = 0; b < NB; b++)
                if (w_strb[b]) r_mem[f_idx(r_waddr)][b*8 +: 8] <= w_data[b*8 +: 8];
        if (w_rd_en)
            r_rmem_q <= r_mem[f_idx(r_raddr)];
    end

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            r_wst <= W_IDLE;  r_wid <= '0;  r_waddr <= '0;  r_wlen <= '0;  r_wbeat <= '0;
            r_wsize <= '0;  r_wburst <= '0;  r_bresp <= '0;  r_werr <= 1'b0;
            r_aw_rdy <= 1'b0;  r_w_rdy <= 1'b0;  r_b_vld <= 1'b0;
        end else begin
            case (r_wst)
                W_IDLE: begin
                    r_aw_rdy <= 1'b1;
                    if (aw_valid && r_aw_rdy) begin
                        r_aw_rdy <= 1'b0;  r_w_rdy <= 1'b1;
                        r_wid <= aw_id;  r_waddr <= aw_addr;  r_wlen <= aw_len;
                        r_wsize <= aw_size;  r_wburst <= aw_burst;
                        r_wbeat <= '0;  r_werr <= 1'b0;  r_wst <= W_DATA;
                    end
                end
                W_DATA: if (w_wfire) begin
                    r_waddr <= w_wnext;  r_wbeat <= r_wbeat + 8'd1;  r_werr <= w_werr_nxt;
                    if (w_wlast_beat) begin
                        r_w_rdy <= 1'b0;  r_b_vld <= 1'b1;
                        r_bresp <= w_werr_nxt ? RESP_SLVERR : RESP_OKAY;
                        r_wst   <= W_RESP;
                    end
                end
                W_RESP: if (b_ready) begin
                    r_b_vld <= 1'b0;  r_aw_rdy <= 1'b1;  r_wst <= W_IDLE;
                end
                default: r_wst <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            r_rst <= R_IDLE;  r_rid <= '0;  r_raddr <= '0;  r_rlen <= '0;  r_rbeat <= '0;
            r_rsize <= '0;  r_rburst <= '0;  r_rresp <= '0;
            r_ar_rdy <= 1'b0;  r_rd_vld <= 1'b0;  r_rlast <= 1'b0;
        end else begin
            case (r_rst)
                R_IDLE: begin
                    r_ar_rdy <= 1'b1;
                    if (ar_valid && r_ar_rdy) begin
                        r_ar_rdy <= 1'b0;
                        r_rid <= ar_id;  r_raddr <= ar_addr;  r_rlen <= ar_len;
                        r_rsize <= ar_size;  r_rburst <= ar_burst;
                        r_rbeat <= '0;  r_rst <= R_READ;
                    end
                end
                R_READ: begin
                    r_raddr  <= w_rnext;
                    r_rd_vld <= 1'b1;
                    r_rlast  <= (r_rlen == 8'd0);
                    r_rresp  <= f_ok(r_raddr, r_rsize) ? RESP_OKAY : RESP_SLVERR;
                    r_rst    <= R_DATA;
                end
                R_DATA: if (r_ready) begin
                    if (r_rlast) begin
                        r_rd_vld <= 1'b0;  r_rlast <= 1'b0;  r_ar_rdy <= 1'b1;  r_rst <= R_IDLE;
                    end else begin
                        // Next beat is fetched on the handshake edge for 1 beat/cycle.
                        r_raddr <= w_rnext;
                        r_rbeat <= r_rbeat + 8'd1;
                        r_rlast <= ((r_rbeat + 8'd1) == r_rlen);
                        r_rresp <= f_ok(r_raddr, r_rsize) ? RESP_OKAY : RESP_SLVERR;
                    end
                end
                default: r_rst <= R_IDLE;
            endcase
        end
    end

endmodule
